// File: rtl/uart_irq_scheduler.sv
// UART interrupt scheduler: sticky source latching, clear sequencing, 16550 priority
// encoding into a registered IIR code and irq line, plus the rx character timeout.
module uart_irq_scheduler #(
    parameter int TOUT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        ier,
    input  logic              baud_tick,
    input  logic [TOUT_W-1:0] tout_limit,
    input  logic              rx_ready,
    input  logic              rx_push,
    input  logic              rbr_rd,
    input  logic              tx_empty,
    input  logic              thr_wr,
    input  logic              lsr_err,
    input  logic              lsr_rd,
    input  logic              msr_change,
    input  logic              msr_rd,
    input  logic              iir_rd,
    output logic              irq,
    output logic [3:0]        iir,
    output logic              timeout_flag
);

    logic              ls_pend, ms_pend, thre_pend, to_pend;
    logic              tx_empty_q, ier1_q;
    logic [TOUT_W-1:0] cnt;

    logic              rx_clr, thre_set, thre_clr, to_hit;
    logic              ls_m, rx_m, to_m, th_m, ms_m;
    logic [3:0]        iir_d;
    logic              irq_d;

    // Any rx activity or an empty receiver restarts the character timeout.
    assign rx_clr   = ~rx_ready | rx_push | rbr_rd;
    assign to_hit   = rx_ready & (tout_limit != '0) & (cnt == tout_limit);
    assign thre_set = (tx_empty & ~tx_empty_q) | (ier[1] & ~ier1_q & tx_empty);
    // Clear on IIR read uses the registered code the host actually saw.
    assign thre_clr = thr_wr | (iir_rd & (iir == 4'b0010));

    always_comb begin
        ls_m  = ls_pend & ier[2];
        rx_m  = rx_ready & ier[0];
        to_m  = to_pend & ier[0];
        th_m  = thre_pend & ier[1];
        ms_m  = ms_pend & ier[3];
        irq_d = ls_m | rx_m | to_m | th_m | ms_m;
        iir_d = 4'b0001;
        if (ls_m)      iir_d = 4'b0110;
        else if (rx_m) iir_d = 4'b0100;
        else if (to_m) iir_d = 4'b1100;
        else if (th_m) iir_d = 4'b0010;
        else if (ms_m) iir_d = 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_pend    <= 1'b0;
            ms_pend    <= 1'b0;
            thre_pend  <= 1'b0;
            to_pend    <= 1'b0;
            tx_empty_q <= 1'b0;
            ier1_q     <= 1'b0;
            cnt        <= '0;
            iir        <= 4'b0001;
            irq        <= 1'b0;
        end else begin
            tx_empty_q <= tx_empty;
            ier1_q     <= ier[1];

            if (lsr_err)     ls_pend <= 1'b1;
            else if (lsr_rd) ls_pend <= 1'b0;

            if (msr_change)  ms_pend <= 1'b1;
            else if (msr_rd) ms_pend <= 1'b0;

            if (thre_set)      thre_pend <= 1'b1;
            else if (thre_clr) thre_pend <= 1'b0;

            if (rx_clr)
                cnt <= '0;
            else if (baud_tick && cnt < tout_limit)
                cnt <= cnt + TOUT_W'(1);

            if (rx_clr)      to_pend <= 1'b0;
            else if (to_hit) to_pend <= 1'b1;

            iir <= iir_d;
            irq <= irq_d;
        end
    end

    assign timeout_flag = to_pend;

endmodule

// File: tb/tb_uart_irq_scheduler.sv
// Directed bench: stimulus pushes expected {iir, irq, timeout_flag} snapshots into a
// queue; a monitor on the falling edge pops and compares them against the DUT.
module tb_uart_irq_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ier;
    logic       baud_tick;
    logic [9:0] tout_limit;
    logic       rx_ready, rx_push, rbr_rd, tx_empty, thr_wr;
    logic       lsr_err, lsr_rd, msr_change, msr_rd, iir_rd;
    logic       irq;
    logic [3:0] iir;
    logic       timeout_flag;

    typedef struct {
        string      name;
        logic [3:0] iir;
        logic       irq;
        logic       tf;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_irq_scheduler #(.TOUT_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .ier(ier), .baud_tick(baud_tick),
        .tout_limit(tout_limit), .rx_ready(rx_ready), .rx_push(rx_push),
        .rbr_rd(rbr_rd), .tx_empty(tx_empty), .thr_wr(thr_wr),
        .lsr_err(lsr_err), .lsr_rd(lsr_rd), .msr_change(msr_change),
        .msr_rd(msr_rd), .iir_rd(iir_rd), .irq(irq), .iir(iir),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    // Monitor: every expectation pushed before this falling edge is checked here.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            if (iir !== e.iir || irq !== e.irq || timeout_flag !== e.tf) begin
                bad++;
                $display("FAIL %s: got iir=%b irq=%b tflag=%b, want iir=%b irq=%b tflag=%b",
                         e.name, iir, irq, timeout_flag, e.iir, e.irq, e.tf);
            end
        end
    end

    task automatic expect_out(input string n, input logic [3:0] i, input logic q,
                              input logic t);
        exp_t e;
        e.name = n; e.iir = i; e.irq = q; e.tf = t;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic baud(input int n);
        repeat (n) begin
            baud_tick = 1'b1; step(1);
            baud_tick = 1'b0; step(1);
        end
    endtask

    initial begin
        rst_n = 1'b0; ier = 4'b0000; baud_tick = 1'b0; tout_limit = 10'd0;
        rx_ready = 1'b0; rx_push = 1'b0; rbr_rd = 1'b0; tx_empty = 1'b1;
        thr_wr = 1'b0; lsr_err = 1'b0; lsr_rd = 1'b0; msr_change = 1'b0;
        msr_rd = 1'b0; iir_rd = 1'b0;
        #1 expect_out("in_reset", 4'b0001, 1'b0, 1'b0);
        #11 rst_n = 1'b1;

        // THRE raised by empty transmitter after reset, masked until ier[1]
        step(1);
        expect_out("post_reset", 4'b0001, 1'b0, 1'b0);
        ier = 4'b0010;
        step(2);
        expect_out("thre_enable", 4'b0010, 1'b1, 1'b0);
        iir_rd = 1'b1;
        step(1);
        iir_rd = 1'b0;
        expect_out("iir_rd_hold", 4'b0010, 1'b1, 1'b0);
        step(1);
        expect_out("thre_clr_iir", 4'b0001, 1'b0, 1'b0);

        // Line status over rx over THRE
        ier = 4'b0111; lsr_err = 1'b1; rx_ready = 1'b1; tx_empty = 1'b0;
        step(1);
        lsr_err = 1'b0; tx_empty = 1'b1;
        step(1);
        expect_out("ls_top", 4'b0110, 1'b1, 1'b0);
        lsr_rd = 1'b1;
        step(1);
        lsr_rd = 1'b0;
        step(1);
        expect_out("rx_next", 4'b0100, 1'b1, 1'b0);
        rbr_rd = 1'b1; rx_ready = 1'b0;
        step(1);
        rbr_rd = 1'b0;
        expect_out("thre_kept", 4'b0010, 1'b1, 1'b0);
        thr_wr = 1'b1;
        step(1);
        thr_wr = 1'b0;
        step(1);
        expect_out("thre_clr_wr", 4'b0001, 1'b0, 1'b0);

        // Character timeout
        tout_limit = 10'd4; rx_ready = 1'b1; ier = 4'b0001;
        baud(4);
        expect_out("timeout_rx_wins", 4'b0100, 1'b1, 1'b1);
        rx_ready = 1'b0;
        step(1);
        expect_out("timeout_code", 4'b1100, 1'b1, 1'b0);
        step(1);
        expect_out("timeout_gone", 4'b0001, 1'b0, 1'b0);
        rx_ready = 1'b1;
        baud(4);
        expect_out("timeout_again", 4'b0100, 1'b1, 1'b1);
        rbr_rd = 1'b1;
        step(1);
        rbr_rd = 1'b0;
        expect_out("rbr_clr_to", 4'b0100, 1'b1, 1'b0);
        baud(3);
        baud_tick = 1'b1;
        step(1);
        baud_tick = 1'b0; rbr_rd = 1'b1;
        step(1);
        rbr_rd = 1'b0;
        expect_out("to_clr_wins", 4'b0100, 1'b1, 1'b0);
        step(1);
        expect_out("to_clr_wins2", 4'b0100, 1'b1, 1'b0);

        // Timeout disabled
        tout_limit = 10'd0;
        baud(100);
        expect_out("tout_disabled", 4'b0100, 1'b1, 1'b0);

        // Line status set wins over simultaneous clear
        ier = 4'b0100; rx_ready = 1'b0; lsr_err = 1'b1; lsr_rd = 1'b1;
        step(1);
        lsr_err = 1'b0; lsr_rd = 1'b0;
        step(1);
        expect_out("ls_set_wins", 4'b0110, 1'b1, 1'b0);
        lsr_rd = 1'b1;
        step(1);
        lsr_rd = 1'b0;
        step(1);
        expect_out("ls_clr", 4'b0001, 1'b0, 1'b0);

        // Modem status, enable masking, async reset
        ier = 4'b1000; msr_change = 1'b1; msr_rd = 1'b1;
        step(1);
        msr_change = 1'b0; msr_rd = 1'b0;
        step(1);
        expect_out("ms_set_wins", 4'b0000, 1'b1, 1'b0);
        ier = 4'b0000;
        step(1);
        expect_out("ier_off", 4'b0001, 1'b0, 1'b0);
        ier = 4'b1000;
        step(1);
        expect_out("ier_on_persist", 4'b0000, 1'b1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        expect_out("async_rst", 4'b0001, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
        expect_out("rst_clears_ms", 4'b0001, 1'b0, 1'b0);

        step(2);
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_irq_scheduler.md
Name: uart_irq_scheduler

Overview:
- Owns the UART interrupt resource: latches the sticky interrupt sources, sequences their clearing from register-access events, and arbitrates them by fixed 16550 priority.
- Presents a registered IIR-style identification code and a single irq line to the host bus.
- Sits between the rx/tx datapath and status logic and the register file; also runs the rx character-timeout counter.

Parameters:
- TOUT_W, 10, width of the character-timeout counter and of the tout_limit input.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- ier  input  4  enables: [0] rx data/timeout, [1] THR empty, [2] line status, [3] modem status
- baud_tick  input  1  one-cycle pulse per bit time from the baud generator
- tout_limit  input  TOUT_W  timeout length in baud ticks; 0 disables timeout
- rx_ready  input  1  level: rx FIFO/holding register non-empty
- rx_push  input  1  pulse: character written into rx FIFO
- rbr_rd  input  1  pulse: host read of RBR
- tx_empty  input  1  level: THR/tx FIFO empty
- thr_wr  input  1  pulse: host write of THR
- lsr_err  input  1  pulse: overrun, parity, framing or break detected
- lsr_rd  input  1  pulse: host read of LSR
- msr_change  input  1  pulse: modem status delta
- msr_rd  input  1  pulse: host read of MSR
- iir_rd  input  1  pulse: host read of IIR
- irq  output  1  interrupt request, active high
- iir  output  4  {id[2:0], pending_n}
- timeout_flag  output  1  unmasked timeout pending, for debug/status

Behaviour:
- Reset: irq=0; iir=4'b0001; all pending bits=0; counter=0; tx_empty_q=0. An empty transmitter therefore raises thre_pend in the first cycle after reset.
- ls_pend:
  - Set by lsr_err; cleared by lsr_rd.
  - Set wins when both occur in the same cycle.
- ms_pend:
  - Set by msr_change; cleared by msr_rd.
  - Set wins when both occur in the same cycle.
- thre_pend set conditions:
  - Rising edge of tx_empty (tx_empty & ~tx_empty_q).
  - Rising edge of ier[1] while tx_empty=1.
- thre_pend clear conditions:
  - thr_wr.
  - iir_rd in a cycle where iir==4'b0010.
  - Set wins over either clear.
- rx data source: rx_ready level, not latched.
- Timeout counter:
  - Clears to 0 when rx_ready=0, or on rx_push or rbr_rd.
  - Otherwise increments on baud_tick and saturates at tout_limit.
- to_pend:
  - Set when rx_ready=1, tout_limit!=0 and counter==tout_limit.
  - Cleared by rbr_rd, rx_push or rx_ready=0. Clear wins over set.
  - timeout_flag=to_pend.
- Masking: ls=ls_pend&ier[2]; rx=rx_ready&ier[0]; to=to_pend&ier[0]; th=thre_pend&ier[1]; ms=ms_pend&ier[3].
- Priority, highest first, with iir value:
  - ls: 0110
  - rx: 0100
  - to: 1100
  - th: 0010
  - ms: 0000
  - none: 0001
- Latency:
  - iir and irq are registered, one cycle after the pending/masked state changes.
  - irq = OR of the masked sources, registered.
  - Disabling an ier bit drops irq/iir on the next cycle; pending bits persist.
- iir holds its value in the iir_rd cycle. The THRE clear is decided on the registered iir value, so a higher-priority source arriving in the same cycle does not lose thre_pend.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); no pending source survives.

Test Plan:
- Reset with tx_empty=1, ier=0 → irq=0, iir=0001. Then ier=4'b0010 → irq=1, iir=0010 two cycles later. Then iir_rd → iir=0001, irq=0.
- ier=4'b0111, pulse lsr_err and raise rx_ready in the same cycle → iir=0110. Then lsr_rd → iir=0100. Then rbr_rd with rx_ready→0 → iir=0010 (THRE still pending).
- tout_limit=4, rx_ready=1, ier[0]=1, 4 baud_ticks with no push/read → timeout_flag=1 and iir=1100 when the rx data source is masked by the test harness forcing priority. With rx_ready=1, confirm iir=0100 (rx outranks timeout). Then rbr_rd → timeout_flag=0, counter=0.
- tout_limit=0, rx_ready=1 for 100 baud_ticks → timeout_flag stays 0.
- lsr_err and lsr_rd in the same cycle → ls_pend=1 (set wins). rbr_rd and counter reaching limit in the same cycle → to_pend=0 (clear wins).
- msr_change with ier=4'b1000 → iir=0000, irq=1. Assert rst_n=0 mid-state → irq=0, iir=0001 asynchronously, and pending bits clear.
